top_share_arb: RTL and testbench

- Scheduler that time-shares a single `top` datapath instance (ports `in0`, `in1`, `clk`, `out`) between NUM_REQ independent requesters.
- Grants one requester per cycle in round-robin order and drives the granted operand pair onto `top`'s inputs.
- Tracks each in-flight operation through a tag pipeline matched to `top`'s latency, then returns the sampled `out` to the originating requester.
- Sits between the requester logic and `u_top`; it is fully synchronous to the same clock.

---
 rtl/top_share_arb_pkg.sv | 19 +
 rtl/top_share_arb_if.sv | 23 ++
 rtl/top_share_arb_rr_arb.sv | 36 +++
 rtl/top_share_arb.sv | 97 +++++++++
 tb/tb_top_share_arb.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/top_share_arb_pkg.sv
// Shared types and constants for the round-robin scheduler in front of the shared `top` datapath.
package top_share_arb_pkg;

  // Tag ids are sized for the largest supported requester count, so one tag type serves every NUM_REQ.
  localparam int   MAX_REQ      = 8;
  localparam int   ID_W         = (MAX_REQ > 1) ? $clog2(MAX_REQ) : 1;
  localparam logic IDLE_VAL_DEF = 1'b0;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] cur, input int n);
    if (int'(cur) >= n - 1) return '0;
    return cur + ID_W'(1);
  endfunction

endpackage

// File: rtl/top_share_arb_if.sv
// Requester-side bundle: operation request/grant handshake and the response strobe.
interface top_share_arb_if #(
  parameter int NUM_REQ = 4
);
  logic               en;
  logic [NUM_REQ-1:0] req_vld;
  logic [NUM_REQ-1:0] req_in0;
  logic [NUM_REQ-1:0] req_in1;
  logic [NUM_REQ-1:0] req_rdy;
  logic [NUM_REQ-1:0] rsp_vld;
  logic               rsp_data;
  logic               busy;

  modport master (
    output en, req_vld, req_in0, req_in1,
    input  req_rdy, rsp_vld, rsp_data, busy
  );

  modport slave (
    input  en, req_vld, req_in0, req_in1,
    output req_rdy, rsp_vld, rsp_data, busy
  );
endinterface

// File: rtl/top_share_arb_rr_arb.sv
// Combinational round-robin picker: first set request at or above ptr, else wraps to the lowest set one.
module rr_arb
  import top_share_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    winner,
  output logic               found
);

  always_comb begin
    gnt    = '0;
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (ID_W'(i) >= ptr)) begin
        found  = 1'b1;
        winner = ID_W'(i);
      end
    end
    // Wrap-around pass only matters when nothing at or above ptr is requesting.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        found  = 1'b1;
        winner = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt[i] = found && (winner == ID_W'(i));
    end
  end

endmodule

// File: rtl/top_share_arb.sv
// Time-shares one `top` datapath among NUM_REQ requesters; a tag pipeline matched to LAT routes results back.
module top_share_arb
  import top_share_arb_pkg::*;
#(
  parameter int   NUM_REQ  = 4,
  parameter int   LAT      = 1,
  parameter logic IDLE_VAL = IDLE_VAL_DEF
) (
  input  logic           clk,
  input  logic           rst,
  top_share_arb_if.slave bus,
  output logic           top_in0,
  output logic           top_in1,
  input  logic           top_out
);

  logic [NUM_REQ-1:0] req_mask;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    winner;
  logic               found;
  logic [ID_W-1:0]    ptr_q;

  tag_t               tag_p [LAT+1];
  logic [NUM_REQ-1:0] rsp_vld_n;
  logic [NUM_REQ-1:0] rsp_vld_q;
  logic               rsp_data_q;
  logic               busy_c;

  assign req_mask = bus.en ? bus.req_vld : '0;

  rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req    (req_mask),
    .ptr    (ptr_q),
    .gnt    (gnt),
    .winner (winner),
    .found  (found)
  );

  // The grant is combinational on req_vld, so it is masked while reset is held.
  assign bus.req_rdy = rst ? '0 : gnt;

  // Stage 0: launch the granted operand pair into `top`
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      top_in0 <= IDLE_VAL;
      top_in1 <= IDLE_VAL;
    end else if (found) begin
      top_in0 <= |(gnt & bus.req_in0);
      top_in1 <= |(gnt & bus.req_in1);
      ptr_q   <= next_ptr(winner, NUM_REQ);
    end else begin
      top_in0 <= IDLE_VAL;
      top_in1 <= IDLE_VAL;
    end
  end

  // Stages 0..LAT: tag shift register, never stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s <= LAT; s++) tag_p[s] <= '0;
    end else begin
      tag_p[0] <= '{vld: found, id: winner};
      for (int s = 1; s <= LAT; s++) tag_p[s] <= tag_p[s-1];
    end
  end

  always_comb begin
    rsp_vld_n = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_vld_n[i] = tag_p[LAT].vld && (tag_p[LAT].id == ID_W'(i));
    end
  end

  always_comb begin
    busy_c = 1'b0;
    for (int s = 0; s <= LAT; s++) busy_c = busy_c | tag_p[s].vld;
  end

  // Final stage: sample `top` output and steer it to the originating requester
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_vld_q  <= '0;
      rsp_data_q <= 1'b0;
    end else begin
      rsp_vld_q  <= rsp_vld_n;
      rsp_data_q <= top_out;
    end
  end

  assign bus.rsp_vld  = rsp_vld_q;
  assign bus.rsp_data = rsp_data_q;
  assign bus.busy     = busy_c;

endmodule

// File: tb/tb_top_share_arb.sv
// Directed bench for top_share_arb with a stand-in `top` datapath (out = in0 | ~in1, one cycle latency).
module tb_top_share_arb;

  localparam int N = 4;

  typedef struct {
    int   due;
    int   id;
    logic dat;
  } exp_t;

  logic clk;
  logic rst;
  logic top_in0;
  logic top_in1;
  logic top_out;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   mptr     = 0;
  exp_t sb[$];

  top_share_arb_if #(.NUM_REQ(N)) bus ();

  top_share_arb #(
    .NUM_REQ  (N),
    .LAT      (1),
    .IDLE_VAL (1'b0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .top_in0 (top_in0),
    .top_in1 (top_in1),
    .top_out (top_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) top_out <= top_in0 | ~top_in1;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic dp(input logic a, input logic b);
    return a | ~b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant();
    logic [N-1:0] v;
    int           i;
    v = bus.req_vld;
    if (rst || !bus.en) return -1;
    for (int k = 0; k < N; k++) begin
      i = (mptr + k) % N;
      if (((v >> i) & 4'b0001) != 4'b0000) return i;
    end
    return -1;
  endfunction

  task automatic drive(input logic e, input logic [N-1:0] v, input logic [N-1:0] i0, input logic [N-1:0] i1);
    bus.en      = e;
    bus.req_vld = v;
    bus.req_in0 = i0;
    bus.req_in1 = i1;
  endtask

  task automatic check_reset_values();
    chk("rst_req_rdy", 32'(bus.req_rdy), 32'(0));
    chk("rst_rsp_vld", 32'(bus.rsp_vld), 32'(0));
    chk("rst_rsp_data", 32'(bus.rsp_data), 32'(0));
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_top_in0", 32'(top_in0), 32'(0));
    chk("rst_top_in1", 32'(top_in1), 32'(0));
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle();
    int           w;
    logic [N-1:0] g;
    logic         e0;
    logic         e1;
    logic [N-1:0] a;
    logic [N-1:0] b;
    exp_t         e;
    #1;
    w = model_grant();
    g = (w >= 0) ? N'(1) << w : '0;
    chk("req_rdy", 32'(bus.req_rdy), 32'(g));
    e0 = 1'b0;
    e1 = 1'b0;
    if (w >= 0) begin
      a  = bus.req_in0 >> w;
      b  = bus.req_in1 >> w;
      e0 = a[0];
      e1 = b[0];
      sb.push_back('{cyc + 3, w, dp(e0, e1)});
      mptr = (w + 1) % N;
    end
    @(posedge clk);
    cyc++;
    #1;
    chk("top_in0", 32'(top_in0), 32'(e0));
    chk("top_in1", 32'(top_in1), 32'(e1));
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("rsp_vld", 32'(bus.rsp_vld), 32'(N'(1) << e.id));
      chk("rsp_data", 32'(bus.rsp_data), 32'(e.dat));
    end else begin
      chk("rsp_vld_idle", 32'(bus.rsp_vld), 32'(0));
    end
    chk("busy", 32'(bus.busy), 32'(sb.size() > 0));
    @(negedge clk);
  endtask

  task automatic apply_reset(input int hold);
    rst = 1'b1;
    #1;
    check_reset_values();
    sb.delete();
    mptr = 0;
    repeat (hold) cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, '0, '0);
    #2;
    check_reset_values();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset then idle
    drive(1'b1, '0, '0, '0);
    repeat (20) cycle();

    // Single request from requester 2 with operands (1,1)
    drive(1'b1, 4'b0100, 4'b0100, 4'b0100);
    cycle();
    drive(1'b1, '0, '0, '0);
    repeat (3) cycle();

    // Fairness from reset with everyone requesting
    @(negedge clk);
    apply_reset(1);
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 4'b1111, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      cycle();
    end
    drive(1'b1, '0, '0, '0);
    repeat (3) cycle();

    // Skip and wrap: move ptr to 3, then alternate 0/2
    drive(1'b1, 4'b0100, 4'b0000, 4'b0100);
    cycle();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 4'b0101, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      cycle();
    end
    drive(1'b1, '0, '0, '0);
    repeat (3) cycle();

    // Enable drop after three grants; pipeline drains
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 4'b1111, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      cycle();
    end
    drive(1'b0, 4'b1111, 4'b1111, 4'b0000);
    repeat (4) cycle();

    // Mid-flight reset discards two outstanding operations
    drive(1'b1, 4'b1111, 4'b1010, 4'b0101);
    cycle();
    cycle();
    apply_reset(2);
    drive(1'b1, 4'b1111, 4'b0001, 4'b0000);
    cycle();
    drive(1'b1, '0, '0, '0);
    repeat (3) cycle();

    // Randomised traffic with enable toggling
    for (int k = 0; k < 40; k++) begin
      drive(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      cycle();
    end
    drive(1'b1, '0, '0, '0);
    repeat (3) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
